// File: rtl/pmem_line_adaptor_if.sv
// Bus bundle between the cache pmem port, the line adaptor and the burst memory.
// slave = adaptor side, master = cache/memory environment side.
interface pmem_line_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
);
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_address;
    logic [LINE_W-1:0]  pmem_wdata;
    logic [LINE_W-1:0]  pmem_rdata;
    logic               pmem_resp;
    logic [31:0]        burst_address;
    logic               burst_read;
    logic               burst_write;
    logic [BURST_W-1:0] burst_wdata;
    logic [BURST_W-1:0] burst_rdata;
    logic               burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output burst_address, burst_read, burst_write, burst_wdata,
        input  burst_rdata, burst_resp
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  burst_address, burst_read, burst_write, burst_wdata,
        output burst_rdata, burst_resp
    );
endinterface

// File: rtl/pmem_line_adaptor.sv
// Whole-line cache pmem responder issuing BEATS-beat bursts to memory.
// Optional perf counters enabled by defining PMEM_ADAPTOR_PERF_EN.
module pmem_line_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int BEATS   = LINE_W / BURST_W
) (
    input  logic                 clk,
    input  logic                 rst,
    pmem_line_adaptor_if.slave   bus
`ifdef PMEM_ADAPTOR_PERF_EN
    ,
    output logic [31:0]          perf_reads,
    output logic [31:0]          perf_writes,
    output logic [31:0]          perf_stalls
`endif
);
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [BEAT_W-1:0]              r_beat;
    logic [31:0]                    r_addr;
    logic [BEATS-1:0][BURST_W-1:0]  r_wbuf;
    logic [BEATS-1:0][BURST_W-1:0]  r_rdata;
    logic                           w_last;
    logic                           w_accept;
    logic [4:0]                     w_unused_addr_lo;

    assign w_unused_addr_lo = bus.pmem_address[4:0];
    assign w_last   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_accept = (r_state == S_IDLE) && (bus.pmem_write || bus.pmem_read);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.pmem_write)     w_next = S_WR;
                else if (bus.pmem_read) w_next = S_RD;
            end
            S_RD:    if (bus.burst_resp && w_last) w_next = S_DONE;
            S_WR:    if (bus.burst_resp && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counter wraps naturally to 0 on the last beat since BEATS is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat  <= '0;
            r_addr  <= '0;
            r_wbuf  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= {bus.pmem_address[31:5], 5'b0};
                r_beat <= '0;
                if (bus.pmem_write) r_wbuf <= bus.pmem_wdata;
            end
            if (r_state == S_RD && bus.burst_resp) begin
                r_rdata[r_beat] <= bus.burst_rdata;
                r_beat          <= r_beat + 1'b1;
            end
            if (r_state == S_WR && bus.burst_resp) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign bus.pmem_rdata    = r_rdata;
    assign bus.pmem_resp     = (r_state == S_DONE);
    assign bus.burst_address = r_addr;
    assign bus.burst_read    = (r_state == S_RD);
    assign bus.burst_write   = (r_state == S_WR);
    assign bus.burst_wdata   = (r_state == S_WR) ? r_wbuf[r_beat] : '0;

`ifdef PMEM_ADAPTOR_PERF_EN
    logic [31:0] r_perf_reads;
    logic [31:0] r_perf_writes;
    logic [31:0] r_perf_stalls;
    logic        w_busy;

    assign w_busy = (r_state == S_RD) || (r_state == S_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_state == S_RD && bus.burst_resp && w_last && r_perf_reads != '1)
                r_perf_reads <= r_perf_reads + 32'd1;
            if (r_state == S_WR && bus.burst_resp && w_last && r_perf_writes != '1)
                r_perf_writes <= r_perf_writes + 32'd1;
            if (w_busy && !bus.burst_resp && r_perf_stalls != '1)
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_reads  = r_perf_reads;
    assign perf_writes = r_perf_writes;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: doc/pmem_line_adaptor.md
Name: pmem_line_adaptor

Overview:
- Responder side of the cache's physical-memory port.
- Accepts whole-line read/write requests (256-bit line, 32-bit address) from the cache datapath/control and answers with a single-cycle response.
- Toward main memory, issues 4-beat 64-bit bursts on the burst-memory interface.
- Sits between the cache's pmem port and the burst DRAM model / arbiter.

Parameters:
- LINE_W, 256, cache line width in bits
- BURST_W, 64, width of one memory beat in bits
- BEATS, LINE_W/BURST_W (4), beats per line; must be a power of two ≥ 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- pmem_read  input  1  cache requests line read; held until pmem_resp
- pmem_write  input  1  cache requests line write-back; held until pmem_resp
- pmem_address  input  32  line address from cache; low 5 bits ignored
- pmem_wdata  input  LINE_W  line to write back
- pmem_rdata  output  LINE_W  assembled read line
- pmem_resp  output  1  one-cycle completion pulse to cache
- burst_address  output  32  line-aligned address to memory
- burst_read  output  1  burst read request
- burst_write  output  1  burst write request
- burst_wdata  output  BURST_W  current write beat
- burst_rdata  input  BURST_W  current read beat
- burst_resp  input  1  memory beat handshake; one beat per high cycle

Behaviour:
- Reset: state IDLE, beat counter 0, all outputs 0 (pmem_rdata, burst_address, burst_wdata cleared). Reset mid-burst aborts immediately; burst_read/burst_write drop the next cycle. Partial data is discarded and no pmem_resp is issued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Samples pmem_write, then pmem_read.
  - Write has priority if both are high (illegal from cache, but defined).
  - On accept, latch burst_address = {pmem_address[31:5],5'b0} and latch pmem_wdata into a line buffer (write only). Clear beat counter.
  - Go to WR/RD. burst_resp in IDLE is ignored.
- RD:
  - burst_read=1.
  - Each cycle burst_resp=1: store burst_rdata into line bits [BURST_W*k+BURST_W-1 : BURST_W*k], k = beat counter; increment k.
  - Cycles with burst_resp=0 are stalls: no change.
  - On beat k=BEATS-1 with burst_resp=1: go to DONE. burst_read deasserts on the same edge.
- WR:
  - burst_write=1; burst_wdata = buffer beat k, combinationally from the counter.
  - Each burst_resp=1 cycle advances k; last beat goes to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle, then IDLE.
  - Requests are not accepted in DONE; the cache must drop pmem_read/pmem_write in the cycle pmem_resp is high. The earliest next acceptance is the cycle after DONE.
- Latency: with burst_resp held high, a request seen in IDLE at cycle 0 gives bursts in cycles 1–4 and pmem_resp in cycle 5.
- pmem_rdata holds the last completed read line until the next read's beats overwrite it. Writes never modify pmem_rdata.
- burst_address is stable for the entire burst; the latched copy, not pmem_address, is used.
- Beat counter is log2(BEATS) bits and wraps to 0 on entering DONE.
- pmem_address/pmem_wdata changes during a transaction have no effect.

Optional Feature:
- Macro: PMEM_ADAPTOR_PERF_EN.
- When defined:
  - Adds outputs perf_reads (32), perf_writes (32), perf_stalls (32).
  - perf_reads / perf_writes increment on entry to DONE from RD / WR.
  - perf_stalls increments every RD/WR cycle with burst_resp=0.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- When undefined: ports and logic are absent; functional behaviour is identical.

Test Plan:
- Read, no stalls: pmem_read=1, pmem_address=32'h0000_1234, memory returns beats 64'hA0..A3 with burst_resp high 4 cycles.
  -> burst_address=32'h0000_1220, pmem_resp one cycle at cycle 5, pmem_rdata={A3,A2,A1,A0}.
- Write with stalls: pmem_write=1, pmem_wdata=256'h{D3,D2,D1,D0}, burst_resp pattern 1,0,1,0,0,1,1.
  -> burst_wdata D0,D1,D1,D2,D2,D2,D3 on those cycles; pmem_resp once after the 4th accepted beat; pmem_rdata unchanged.
- Both pmem_read and pmem_write high in IDLE -> WR path taken, burst_read never asserted.
- Reset asserted after 2 read beats -> next cycle burst_read=0, state IDLE, no pmem_resp; following read of a new address completes normally with fresh data.
- Back-to-back: read completes, cache raises pmem_write the cycle after pmem_resp -> accepted, write burst starts next cycle, address latched from new request.
- PMEM_ADAPTOR_PERF_EN: one read with 3 stall cycles plus one write with 0 stalls -> perf_reads=1, perf_writes=1, perf_stalls=3.
